// File: rtl/axi4_lite_rr_master_arb.sv
// Two-requester round-robin arbiter that serialises single commands onto one AXI4-Lite master port.
// Define AXI_ARB_STATS_EN to add saturating per-requester grant counters on GRANT_CNT0/GRANT_CNT1.
module axi4_lite_rr_master_arb #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WE,
    input  logic [2*ADDRESS-1:0]    REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]              REQ_READY,
    output logic [1:0]              RSP_VALID,
    output logic [DATA_WIDTH-1:0]   RSP_DATA,
    output logic                    RSP_ERR,
    output logic [ADDRESS-1:0]      M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [3:0]              M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ADDRESS-1:0]      M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
`ifdef AXI_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    GRANT_CNT0,
    output logic [CNT_WIDTH-1:0]    GRANT_CNT1
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ADDRESS-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    gnt;
    logic [1:0]              req_ready;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        gnt          = 1'b0;
        req_ready    = 2'b00;

        unique case (state_q)
            IDLE: begin
                // ARESETN gating keeps REQ_READY low while reset is held.
                if (ARESETN && (REQ_VALID != 2'b00)) begin
                    gnt          = (REQ_VALID == 2'b11) ? ~last_grant_q : REQ_VALID[1];
                    req_ready    = gnt ? 2'b10 : 2'b01;
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    addr_d       = gnt ? REQ_ADDR[ADDRESS +: ADDRESS] : REQ_ADDR[0 +: ADDRESS];
                    wdata_d      = gnt ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH]
                                       : REQ_WDATA[0 +: DATA_WIDTH];
                    if (REQ_WE[gnt]) begin
                        state_d   = WR;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; both may complete on the same edge.
                aw_pend_d = aw_pend_q & ~M_AWREADY;
                w_pend_d  = w_pend_q & ~M_WREADY;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_BVALID) begin
                    rsp_data_d = '0;
                    rsp_err_d  = |M_BRESP;
                    state_d    = RESP;
                end
            end
            RD_ADDR: begin
                if (M_ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_RVALID) begin
                    rsp_data_d = M_RDATA;
                    rsp_err_d  = |M_RRESP;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // All master-side valids come straight from flops, never from a same-cycle READY.
    assign REQ_READY = req_ready;
    assign RSP_VALID = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign M_AWADDR  = addr_q;
    assign M_AWVALID = (state_q == WR) && aw_pend_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = 4'hF;
    assign M_WVALID  = (state_q == WR) && w_pend_q;
    assign M_BREADY  = (state_q == WR_RESP);
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = (state_q == RD_ADDR);
    assign M_RREADY  = (state_q == RD_DATA);

`ifdef AXI_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_WIDTH-1:0] grant_cnt1_q, grant_cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (req_ready[0] && (grant_cnt0_q != '1)) begin
            grant_cnt0_d = grant_cnt0_q + CNT_WIDTH'(1);
        end
        if (req_ready[1] && (grant_cnt1_q != '1)) begin
            grant_cnt1_d = grant_cnt1_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign GRANT_CNT0 = grant_cnt0_q;
    assign GRANT_CNT1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_axi4_lite_rr_master_arb.sv
// Self-checking bench: table vectors, hand-written corner sequences and randomized traffic
// against a behavioural arbitration/memory model, with a 32-word AXI4-Lite slave in the bench.
`timescale 1ns/1ps
module tb_axi4_lite_rr_master_arb;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [1:0]      REQ_VALID = '0;
    logic [1:0]      REQ_WE = '0;
    logic [2*AW-1:0] REQ_ADDR = '0;
    logic [2*DW-1:0] REQ_WDATA = '0;
    logic [1:0]      REQ_READY;
    logic [1:0]      RSP_VALID;
    logic [DW-1:0]   RSP_DATA;
    logic            RSP_ERR;
    logic [AW-1:0]   M_AWADDR;
    logic            M_AWVALID;
    logic            M_AWREADY;
    logic [DW-1:0]   M_WDATA;
    logic [3:0]      M_WSTRB;
    logic            M_WVALID;
    logic            M_WREADY;
    logic [1:0]      M_BRESP;
    logic            M_BVALID;
    logic            M_BREADY;
    logic [AW-1:0]   M_ARADDR;
    logic            M_ARVALID;
    logic            M_ARREADY;
    logic [DW-1:0]   M_RDATA;
    logic [1:0]      M_RRESP;
    logic            M_RVALID;
    logic            M_RREADY;
`ifdef AXI_ARB_STATS_EN
    logic [CW-1:0]   GRANT_CNT0;
    logic [CW-1:0]   GRANT_CNT1;
`endif

    axi4_lite_rr_master_arb #(
        .ADDRESS    (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .REQ_VALID  (REQ_VALID),
        .REQ_WE     (REQ_WE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .RSP_ERR    (RSP_ERR),
        .M_AWADDR   (M_AWADDR),
        .M_AWVALID  (M_AWVALID),
        .M_AWREADY  (M_AWREADY),
        .M_WDATA    (M_WDATA),
        .M_WSTRB    (M_WSTRB),
        .M_WVALID   (M_WVALID),
        .M_WREADY   (M_WREADY),
        .M_BRESP    (M_BRESP),
        .M_BVALID   (M_BVALID),
        .M_BREADY   (M_BREADY),
        .M_ARADDR   (M_ARADDR),
        .M_ARVALID  (M_ARVALID),
        .M_ARREADY  (M_ARREADY),
        .M_RDATA    (M_RDATA),
        .M_RRESP    (M_RRESP),
        .M_RVALID   (M_RVALID),
        .M_RREADY   (M_RREADY)
`ifdef AXI_ARB_STATS_EN
        ,
        .GRANT_CNT0 (GRANT_CNT0),
        .GRANT_CNT1 (GRANT_CNT1)
`endif
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave: 32 x 32-bit bank, SLVERR when ADDR[31] is set ----------------
    logic [31:0] slv_mem [32];
    int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit  rand_dly = 1'b0;
    int  aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit  aw_have, w_have, ar_have;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    int  b_count = 0;

    function automatic int pick(input int d);
        return rand_dly ? int'($urandom_range(0, 3)) : d;
    endfunction

    task automatic slv_reload();
        aw_wait = pick(aw_dly);
        w_wait  = pick(w_dly);
        b_wait  = pick(b_dly);
        ar_wait = pick(ar_dly);
        r_wait  = pick(r_dly);
    endtask

    // Decides READY/VALID on the falling edge; DUT valids are flop-driven, so a handshake
    // decided here is certain to occur on the next rising edge.
    initial begin : slave
        foreach (slv_mem[i]) slv_mem[i] = '0;
        {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID} = '0;
        M_BRESP = '0; M_RRESP = '0; M_RDATA = '0;
        {aw_have, w_have, ar_have} = '0;
        slv_reload();
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID} = '0;
                M_BRESP = '0; M_RRESP = '0; M_RDATA = '0;
                {aw_have, w_have, ar_have} = '0;
                slv_reload();
            end else begin
                M_BVALID = 1'b0; M_BRESP = 2'b00;
                if (aw_have && w_have && M_BREADY) begin
                    if (b_wait == 0) begin
                        M_BVALID = 1'b1;
                        M_BRESP  = s_awaddr[31] ? 2'b10 : 2'b00;
                        if (!s_awaddr[31]) slv_mem[s_awaddr[4:0]] = s_wdata;
                        aw_have = 1'b0; w_have = 1'b0; b_count++;
                        aw_wait = pick(aw_dly); w_wait = pick(w_dly); b_wait = pick(b_dly);
                    end else b_wait--;
                end
                M_AWREADY = 1'b0;
                if (M_AWVALID && !aw_have) begin
                    if (aw_wait == 0) begin
                        M_AWREADY = 1'b1; aw_have = 1'b1; s_awaddr = M_AWADDR;
                    end else aw_wait--;
                end
                M_WREADY = 1'b0;
                if (M_WVALID && !w_have) begin
                    if (w_wait == 0) begin
                        M_WREADY = 1'b1; w_have = 1'b1; s_wdata = M_WDATA;
                    end else w_wait--;
                end
                M_RVALID = 1'b0; M_RRESP = 2'b00; M_RDATA = '0;
                if (ar_have && M_RREADY) begin
                    if (r_wait == 0) begin
                        M_RVALID = 1'b1;
                        M_RDATA  = slv_mem[s_araddr[4:0]];
                        M_RRESP  = s_araddr[31] ? 2'b10 : 2'b00;
                        ar_have  = 1'b0;
                        ar_wait  = pick(ar_dly); r_wait = pick(r_dly);
                    end else r_wait--;
                end
                M_ARREADY = 1'b0;
                if (M_ARVALID && !ar_have) begin
                    if (ar_wait == 0) begin
                        M_ARREADY = 1'b1; ar_have = 1'b1; s_araddr = M_ARADDR;
                    end else ar_wait--;
                end
            end
        end
    end

    // ---------------- reference model and command engine ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    logic [31:0] ref_mem [32];
    int          ref_last = 1;
    cmd_t        q0[$];
    cmd_t        q1[$];
    int          grant_log[$];
    bit          hold_rand = 1'b0;
    logic [31:0] last_data;
    logic        last_err;
    int          last_owner;

    task automatic run_engine(input int budget);
        bit          busy;
        int          cyc;
        int          k;
        int          exp_owner;
        logic [31:0] exp_data;
        logic        exp_err;
        cmd_t        c;
        busy = 1'b0; cyc = 0; exp_owner = 0; exp_data = '0; exp_err = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
            REQ_VALID = 2'b00;
            if (q0.size() != 0 && (!hold_rand || $urandom_range(0, 3) != 0)) begin
                REQ_VALID[0] = 1'b1; REQ_WE[0] = q0[0].we;
                REQ_ADDR[0 +: AW] = q0[0].addr; REQ_WDATA[0 +: DW] = q0[0].wdata;
            end
            if (q1.size() != 0 && (!hold_rand || $urandom_range(0, 3) != 0)) begin
                REQ_VALID[1] = 1'b1; REQ_WE[1] = q1[0].we;
                REQ_ADDR[AW +: AW] = q1[0].addr; REQ_WDATA[DW +: DW] = q1[0].wdata;
            end
            #1;
            if (!busy && REQ_VALID != 2'b00) begin
                // Round robin: a lone requester wins; on a tie the one not granted last wins.
                if (REQ_VALID == 2'b11) k = 1 - ref_last;
                else k = REQ_VALID[1] ? 1 : 0;
                check("grant", REQ_READY, 64'(2'b01 << k));
                ref_last = k; grant_log.push_back(k); busy = 1'b1; exp_owner = k;
                if (k == 1) c = q1.pop_front();
                else c = q0.pop_front();
                exp_err = c.addr[31];
                if (c.we) begin
                    exp_data = '0;
                    if (!exp_err) ref_mem[c.addr[4:0]] = c.wdata;
                end else begin
                    exp_data = ref_mem[c.addr[4:0]];
                end
            end else begin
                check("no_grant", REQ_READY, 64'h0);
            end
            if (RSP_VALID != 2'b00) begin
                if (busy) begin
                    check("rsp_owner", RSP_VALID, 64'(2'b01 << exp_owner));
                    check("rsp_data", RSP_DATA, exp_data);
                    check("rsp_err", RSP_ERR, exp_err);
                    last_data = RSP_DATA; last_err = RSP_ERR; last_owner = RSP_VALID[1] ? 1 : 0;
                    busy = 1'b0;
                end else begin
                    check("rsp_unexpected", RSP_VALID, 64'h0);
                end
            end
        end
        if (cyc >= budget) begin
            checks++; errors++;
            $display("FAIL engine_timeout: got %0d cycles without completion, expected under %0d", cyc, budget);
            q0.delete(); q1.delete();
        end
        REQ_VALID = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0; REQ_VALID = 2'b00;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        ref_last = 1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [10];
    int   aw_cyc, w_cyc, aw_only, rsp_cnt, bad;
    logic [1:0] rsp_seen;
    bit   found;

    initial begin : main
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset state.
        repeat (2) @(negedge ACLK);
        #1;
        check("rst_req_ready", REQ_READY, 64'h0);
        check("rst_rsp_valid", RSP_VALID, 64'h0);
        check("rst_rsp_data", RSP_DATA, 64'h0);
        check("rst_rsp_err", RSP_ERR, 64'h0);
        check("rst_m_handshake", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 64'h0);
        check("rst_m_addr", {M_AWADDR, M_ARADDR}, 64'h0);
        do_reset();

        // Table-driven single commands; expectations are hand constants.
        vecs[0] = '{0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1, 1'b1, 32'h0000_001F, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[3] = '{0, 1'b0, 32'h0000_001F, 32'h0,         32'h1234_5678, 1'b0};
        vecs[4] = '{0, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{0, 1'b1, 32'h8000_0005, 32'h0000_AAAA, 32'h0000_0000, 1'b1};
        vecs[7] = '{1, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000, 1'b0};
        vecs[8] = '{0, 1'b1, 32'h0000_0024, 32'h0000_0055, 32'h0000_0000, 1'b0};
        vecs[9] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0055, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cmd_t c;
            c.we = vecs[i].we; c.addr = vecs[i].addr; c.wdata = vecs[i].wdata;
            if (vecs[i].req == 1) q1.push_back(c);
            else q0.push_back(c);
            last_data = 'x; last_err = 1'bx; last_owner = -1;
            run_engine(100);
            check($sformatf("vec%0d_owner", i), 64'(last_owner), 64'(vecs[i].req));
            check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
        end

        // Both requesters hold valid continuously: grants alternate starting with 0.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            cmd_t c;
            c.we = 1'b1; c.addr = 32'(8 + i); c.wdata = 32'hA000_0000 + 32'(i);
            q0.push_back(c);
            c.we = 1'b0; c.addr = 32'(8 + i); c.wdata = '0;
            q1.push_back(c);
        end
        run_engine(200);
        check("alt_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("alt_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // AWREADY three cycles after WREADY: W drops, AW held, one B, one RSP pulse.
        aw_dly = 3; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; rand_dly = 1'b0;
        do_reset();
        b_count = 0;
        @(negedge ACLK);
        REQ_VALID = 2'b01; REQ_WE = 2'b01;
        REQ_ADDR[0 +: AW] = 32'h0000_0010; REQ_WDATA[0 +: DW] = 32'hCAFE_F00D;
        #1;
        check("hs_grant", REQ_READY, 64'h1);
        ref_mem[16] = 32'hCAFE_F00D;
        aw_cyc = 0; w_cyc = 0; aw_only = 0; rsp_cnt = 0; bad = 0; rsp_seen = '0;
        @(negedge ACLK);
        REQ_VALID = 2'b00;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge ACLK);
            #1;
            if (M_AWVALID) aw_cyc++;
            if (M_WVALID) w_cyc++;
            if (M_AWVALID && !M_WVALID) aw_only++;
            if (M_WVALID && (M_WDATA !== 32'hCAFE_F00D || M_WSTRB !== 4'hF)) bad++;
            if (M_AWVALID && M_AWADDR !== 32'h0000_0010) bad++;
            if (RSP_VALID != 2'b00) begin rsp_cnt++; rsp_seen = RSP_VALID; end
        end
        check("hs_awvalid_cycles", 64'(aw_cyc), 64'd4);
        check("hs_wvalid_cycles", 64'(w_cyc), 64'd1);
        check("hs_aw_only_cycles", 64'(aw_only), 64'd3);
        check("hs_payload_bad", 64'(bad), 64'd0);
        check("hs_b_count", 64'(b_count), 64'd1);
        check("hs_rsp_count", 64'(rsp_cnt), 64'd1);
        check("hs_rsp_owner", rsp_seen, 64'h1);

        // Reset while waiting in RD_DATA.
        aw_dly = 0; r_dly = 6;
        do_reset();
        @(negedge ACLK);
        REQ_VALID = 2'b01; REQ_WE = 2'b00; REQ_ADDR[0 +: AW] = 32'h0000_0004;
        #1;
        check("mid_grant", REQ_READY, 64'h1);
        @(negedge ACLK);
        REQ_VALID = 2'b00;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (M_RREADY) found = 1'b1;
            else @(negedge ACLK);
        end
        check("mid_reached_rd_data", 64'(found), 64'h1);
        r_dly = 0;
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        check("mid_rst_m_handshake", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 64'h0);
        check("mid_rst_rsp_valid", RSP_VALID, 64'h0);
        check("mid_rst_req_ready", REQ_READY, 64'h0);
        rsp_cnt = 0;
        repeat (3) begin
            @(negedge ACLK); #1;
            if (RSP_VALID != 2'b00) rsp_cnt++;
        end
        ARESETN = 1'b1; ref_last = 1;
        repeat (2) begin
            @(negedge ACLK); #1;
            if (RSP_VALID != 2'b00) rsp_cnt++;
        end
        check("mid_no_rsp_after_abort", 64'(rsp_cnt), 64'd0);
        @(negedge ACLK);
        REQ_VALID = 2'b11; REQ_WE = 2'b00;
        REQ_ADDR[0 +: AW] = 32'h0000_001F; REQ_ADDR[AW +: AW] = 32'h0000_0004;
        #1;
        check("post_rst_tie_grant", REQ_READY, 64'h1);
        @(negedge ACLK);
        REQ_VALID = 2'b00;
        found = 1'b0; rsp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge ACLK);
            #1;
            if (RSP_VALID != 2'b00) begin
                rsp_cnt++;
                if (!found) begin
                    found = 1'b1;
                    check("post_rst_rsp_owner", RSP_VALID, 64'h1);
                    check("post_rst_rsp_data", RSP_DATA, ref_mem[31]);
                    check("post_rst_rsp_err", RSP_ERR, 64'h0);
                end
            end
        end
        check("post_rst_rsp_count", 64'(rsp_cnt), 64'd1);

        // Randomized traffic with random slave delays and requesters dropping valid.
        rand_dly = 1'b1; hold_rand = 1'b1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cmd_t c;
            c.we    = 1'($urandom_range(0, 1));
            c.addr  = $urandom;
            c.addr[31] = ($urandom_range(0, 7) == 0);
            c.wdata = $urandom;
            if ($urandom_range(0, 1) == 1) q1.push_back(c);
            else q0.push_back(c);
        end
        run_engine(6000);
        rand_dly = 1'b0; hold_rand = 1'b0;

`ifdef AXI_ARB_STATS_EN
        // Saturating grant counters (CNT_WIDTH = 2).
        do_reset();
        #1;
        check("cnt0_reset", GRANT_CNT0, 64'h0);
        check("cnt1_reset", GRANT_CNT1, 64'h0);
        for (int i = 0; i < 5; i++) begin
            cmd_t c;
            c.we = 1'b0; c.addr = 32'(i); c.wdata = '0;
            q0.push_back(c);
        end
        run_engine(200);
        @(negedge ACLK); #1;
        check("cnt0_saturated", GRANT_CNT0, 64'd3);
        check("cnt1_idle", GRANT_CNT1, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_rr_master_arb.md
Name: axi4_lite_rr_master_arb

Overview:
- Two-requester, round-robin arbitrated AXI4-Lite master that shares one AXI4-Lite slave register bank (32 x 32-bit, word index = ADDR[4:0]).
- Each requester issues single read or write commands over a simple valid/ready port.
- The block serialises the commands, runs the AXI4-Lite transaction, and returns the response to the owning requester.
- It sits between on-chip command sources (e.g. CPU and DMA config engine) and the slave.

Parameters:
- ADDRESS, 32, AXI and requester address width.
- DATA_WIDTH, 32, data width; WSTRB fixed 4 bits, always 4'hF.
- CNT_WIDTH, 16, width of grant counters (used only with optional feature).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  2  per-requester command valid.
- REQ_WE  in  2  1 = write, 0 = read, per requester.
- REQ_ADDR  in  2*ADDRESS  requester i address in bits [i*ADDRESS +: ADDRESS].
- REQ_WDATA  in  2*DATA_WIDTH  requester i write data, same packing.
- REQ_READY  out  2  one-cycle accept pulse to the granted requester.
- RSP_VALID  out  2  one-cycle completion pulse to the owner.
- RSP_DATA  out  DATA_WIDTH  read data (0 for writes), valid with RSP_VALID.
- RSP_ERR  out  1  1 when BRESP/RRESP != 2'b00, valid with RSP_VALID.
- M_AWADDR, M_AWVALID  out  ADDRESS, 1; M_AWREADY  in  1.
- M_WDATA, M_WSTRB, M_WVALID  out  DATA_WIDTH, 4, 1; M_WREADY  in  1.
- M_BRESP  in  2; M_BVALID  in  1; M_BREADY  out  1.
- M_ARADDR, M_ARVALID  out  ADDRESS, 1; M_ARREADY  in  1.
- M_RDATA  in  DATA_WIDTH; M_RRESP  in  2; M_RVALID  in  1; M_RREADY  out  1.
- GRANT_CNT0, GRANT_CNT1  out  CNT_WIDTH each  present only with AXI_ARB_STATS_EN.

Behaviour:
- States: IDLE, WR (AW+W pending), WR_RESP, RD_ADDR, RD_DATA, RESP.
- Reset: state=IDLE, last_grant=1 (requester 0 wins first tie), owner=0, all outputs 0.
- IDLE arbitration:
  - Only REQ_VALID[k] set: grant k.
  - Both set: grant ~last_grant.
  - On grant: REQ_READY[k]=1 for exactly that cycle; latch owner, WE, ADDR, WDATA; last_grant<=k.
  - Next state is WR if WE else RD_ADDR.
- WR:
  - M_AWVALID and M_WVALID both rise the cycle after grant and are asserted together.
  - Each deasserts independently after its own handshake (AWVALID&AWREADY, WVALID&WREADY).
  - Same-cycle handshakes are legal.
  - Go to WR_RESP once both channels are done.
- WR_RESP: M_BREADY=1. On BVALID, capture RSP_ERR=|BRESP, RSP_DATA=0, go to RESP.
- RD_ADDR: M_ARVALID=1 until M_ARREADY, then RD_DATA.
- RD_DATA: M_RREADY=1. On RVALID, capture RDATA and RSP_ERR=|RRESP, go to RESP.
- RESP: RSP_VALID[owner]=1 for one cycle; RSP_DATA/RSP_ERR stable while RSP_VALID is set; then IDLE.
- Arbitration happens only in IDLE: no new grant while busy, so back-to-back turnaround is one IDLE cycle minimum.
- M_AW/AR addresses and M_WDATA are driven from latched registers and held stable while valid; M_WSTRB=4'hF.
- A requester dropping REQ_VALID before its grant is never served; after the grant, its REQ_* inputs are ignored.
- Reset mid-transaction: immediate return to IDLE, all valids/readys low, pending transaction abandoned, no RSP pulse.
- No other outstanding transactions; read and write never overlap.

Optional Feature:
- AXI_ARB_STATS_EN defined:
  - GRANT_CNT0/1 ports exist.
  - Counter k increments on each REQ_READY[k] pulse and saturates at all-ones (no wrap).
  - Reset clears both counters to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Req0 write addr 0x04 data 0xDEADBEEF, then req1 read 0x04 -> RSP_VALID[1] with RSP_DATA=0xDEADBEEF, RSP_ERR=0.
- Both requesters hold REQ_VALID continuously for 6 commands -> grants alternate 0,1,0,1,0,1 starting with 0 after reset.
- Slave delays AWREADY 3 cycles relative to WREADY -> WVALID drops after its handshake, AWVALID held; a single B collected; one RSP_VALID pulse.
- Slave returns RRESP=2'b10 -> RSP_ERR=1 with RSP_VALID, next command proceeds normally.
- Assert ARESETN low while in RD_DATA -> all M_*VALID/READY and RSP_VALID 0; after release the next req0 is granted first.
- With AXI_ARB_STATS_EN, CNT_WIDTH=2: five req0 grants -> GRANT_CNT0=3 (saturated), GRANT_CNT1=0.
